// File: rtl/stretch_pkg.sv
// Shared state encoding and elaboration-time width helpers for the pulse stretcher.
package stretch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Smallest w such that 2**w >= value.
    function automatic int clog2_f(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/stretch_down_counter.sv
// Loadable down-counter shared by the hold and gap phases; parks at zero.
module stretch_down_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    localparam logic [W-1:0] ZERO_V = {W{1'b0}};
    localparam logic [W-1:0] ONE_V  = W'(1'b1);

    logic [W-1:0] count_r;

    // Count register: load has priority, otherwise decrement until zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= ZERO_V;
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != ZERO_V) begin
            count_r <= count_r - ONE_V;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == ZERO_V);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into HOLD_CYCLES-long levels separated by
// GAP_CYCLES low cycles, queueing (or retriggering on) strobes that arrive while busy.
module pulse_stretcher
    import stretch_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 3,
    parameter bit RETRIGGER   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse_in,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending_cnt,
    output logic              overflow
);

    localparam int                 CNT_W     = clog2_f(max_f(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [PEND_W-1:0]  PEND_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0]  PEND_ONE  = PEND_W'(1'b1);
    localparam logic [PEND_W-1:0]  PEND_MAX  = {PEND_W{1'b1}};

    state_t              state_r;
    state_t              next_state_s;
    logic                level_r;
    logic                busy_r;
    logic [PEND_W-1:0]   pend_r;
    logic [PEND_W-1:0]   pend_next_s;
    logic                ovf_r;
    logic                ovf_next_s;
    logic                load_s;
    logic [CNT_W-1:0]    load_value_s;
    logic                cnt_zero_s;

    stretch_down_counter #(
        .W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .load_value (load_value_s),
        .zero       (cnt_zero_s)
    );

    // Next-state, counter load and queue bookkeeping.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        load_value_s = CNT_ZERO;
        pend_next_s  = pend_r;
        ovf_next_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                pend_next_s = PEND_ZERO;
                if (pulse_in) begin
                    next_state_s = S_HIGH;
                    load_s       = 1'b1;
                    load_value_s = HOLD_LOAD;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_HIGH: begin
                if ((RETRIGGER == 1'b1) && pulse_in) begin
                    next_state_s = S_HIGH;
                    load_s       = 1'b1;
                    load_value_s = HOLD_LOAD;
                end else begin
                    if (pulse_in) begin
                        if (pend_r == PEND_MAX) begin
                            ovf_next_s = 1'b1;
                        end else begin
                            pend_next_s = pend_r + PEND_ONE;
                        end
                    end else begin
                        pend_next_s = pend_r;
                    end
                    if (cnt_zero_s) begin
                        next_state_s = S_GAP;
                        load_s       = 1'b1;
                        load_value_s = GAP_LOAD;
                    end else begin
                        next_state_s = S_HIGH;
                    end
                end
            end
            S_GAP: begin
                if (cnt_zero_s) begin
                    // Dequeue and a same-cycle strobe net out, so a full queue never drops here.
                    if ((pend_r != PEND_ZERO) || pulse_in) begin
                        next_state_s = S_HIGH;
                        load_s       = 1'b1;
                        load_value_s = HOLD_LOAD;
                        pend_next_s  = pend_r + PEND_W'(pulse_in) - PEND_ONE;
                    end else begin
                        next_state_s = S_IDLE;
                    end
                end else begin
                    next_state_s = S_GAP;
                    if (pulse_in) begin
                        if (pend_r == PEND_MAX) begin
                            ovf_next_s = 1'b1;
                        end else begin
                            pend_next_s = pend_r + PEND_ONE;
                        end
                    end else begin
                        pend_next_s = pend_r;
                    end
                end
            end
            default: begin
                next_state_s = S_IDLE;
                load_s       = 1'b1;
                load_value_s = CNT_ZERO;
                pend_next_s  = PEND_ZERO;
            end
        endcase
    end

    // State and registered outputs, all decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            level_r <= 1'b0;
            busy_r  <= 1'b0;
            pend_r  <= PEND_ZERO;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            level_r <= (next_state_s == S_HIGH);
            busy_r  <= (next_state_s != S_IDLE);
            pend_r  <= pend_next_s;
            ovf_r   <= ovf_next_s;
        end
    end

    assign level_out   = level_r;
    assign busy        = busy_r;
    assign pending_cnt = pend_r;
    assign overflow    = ovf_r;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Table-driven bench: per-scenario cycle masks give expected outputs, which are
// queued when stimulus is driven and compared after the following clock edge.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       pulse_in;
    logic       lvl0, bsy0, ovf0, lvl1, bsy1, ovf1;
    logic [1:0] pend0, pend1;

    always #5 clk = ~clk;

    pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2), .RETRIGGER(1'b0)) dut_q (
        .clk(clk), .reset(reset), .pulse_in(pulse_in),
        .level_out(lvl0), .busy(bsy0), .pending_cnt(pend0), .overflow(ovf0)
    );

    pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2), .RETRIGGER(1'b1)) dut_r (
        .clk(clk), .reset(reset), .pulse_in(pulse_in),
        .level_out(lvl1), .busy(bsy1), .pending_cnt(pend1), .overflow(ovf1)
    );

    typedef struct {
        string       name;
        bit          rtg;
        logic [63:0] strobe, rst, lvl, bsy, ovf, p1, p2, p3;
    } vec_t;

    typedef struct packed {
        logic       lvl;
        logic       bsy;
        logic [1:0] pend;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    vec_t tbl[8];

    function automatic logic [63:0] r(input int lo, input int hi);
        logic [63:0] m;
        m = 64'd0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic run(input vec_t v);
        exp_t e, g;
        reset    = 1'b1;
        pulse_in = 1'b1;
        @(posedge clk);
        pulse_in = 1'b0;
        @(posedge clk);
        #1;
        check({v.name, "/reset/level"}, 32'(lvl0 | lvl1), 32'd0);
        check({v.name, "/reset/busy"},  32'(bsy0 | bsy1), 32'd0);
        check({v.name, "/reset/pend"},  32'(pend0 | pend1), 32'd0);
        check({v.name, "/reset/ovf"},   32'(ovf0 | ovf1), 32'd0);
        for (int c = 0; c < 48; c++) begin
            pulse_in = v.strobe[c];
            reset    = v.rst[c];
            e.lvl  = v.lvl[c+1];
            e.bsy  = v.bsy[c+1];
            e.ovf  = v.ovf[c+1];
            e.pend = v.p3[c+1] ? 2'd3 : v.p2[c+1] ? 2'd2 : v.p1[c+1] ? 2'd1 : 2'd0;
            sb.push_back(e);
            @(posedge clk);
            #1;
            g = sb.pop_front();
            check($sformatf("%s/c%0d/level", v.name, c + 1), 32'(v.rtg ? lvl1 : lvl0), 32'(g.lvl));
            check($sformatf("%s/c%0d/busy", v.name, c + 1),  32'(v.rtg ? bsy1 : bsy0), 32'(g.bsy));
            check($sformatf("%s/c%0d/pend", v.name, c + 1),  32'(v.rtg ? pend1 : pend0), 32'(g.pend));
            check($sformatf("%s/c%0d/ovf", v.name, c + 1),   32'(v.rtg ? ovf1 : ovf0), 32'(g.ovf));
        end
        pulse_in = 1'b0;
        reset    = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        pulse_in = 1'b0;
        //        name          rtg   strobe                       rst        level                                           busy       ovf        p1                   p2                   p3
        tbl[0] = '{"single",    1'b0, r(10,10),                    64'd0, r(11,14),                                       r(11,16), 64'd0,    64'd0,               64'd0,               64'd0};
        tbl[1] = '{"queue",     1'b0, r(10,10)|r(12,13),           64'd0, r(11,14)|r(17,20)|r(23,26),                     r(11,28), 64'd0,    r(13,13)|r(17,22),   r(14,16),            64'd0};
        tbl[2] = '{"saturate",  1'b0, r(10,15),                    64'd0, r(11,14)|r(17,20)|r(23,26)|r(29,32),            r(11,34), r(15,16), r(12,12)|r(23,28),   r(13,13)|r(17,22),   r(14,16)};
        tbl[3] = '{"retrig",    1'b1, r(10,10)|r(13,13),           64'd0, r(11,17),                                       r(11,19), 64'd0,    64'd0,               64'd0,               64'd0};
        tbl[4] = '{"midreset",  1'b0, r(10,13)|r(15,15),           r(13,13), r(11,13)|r(16,19),                           r(11,13)|r(16,21), 64'd0, r(12,12),       r(13,13),            64'd0};
        tbl[5] = '{"lastgap",   1'b0, r(10,10)|r(16,16),           64'd0, r(11,14)|r(17,20),                              r(11,22), 64'd0,    64'd0,               64'd0,               64'd0};
        tbl[6] = '{"retrig0",   1'b1, r(10,10)|r(14,14)|r(19,19),  64'd0, r(11,18)|r(21,24),                              r(11,26), 64'd0,    r(20,20),            64'd0,               64'd0};
        tbl[7] = '{"fullgap",   1'b0, r(10,13)|r(16,16),           64'd0, r(11,14)|r(17,20)|r(23,26)|r(29,32)|r(35,38),   r(11,40), 64'd0,    r(12,12)|r(29,34),   r(13,13)|r(23,28),   r(14,22)};
        for (int s = 0; s < 8; s++) run(tbl[s]);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
